// File: rtl/clock_pkg.sv
// Shared types and constants for the clock/alarm datapath.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  typedef logic [1:0] hr10_t;
  typedef logic [3:0] dig_t;
  typedef logic [2:0] min10_t;

  localparam hr10_t ALM_RST_HR10 = 2'd0;
  localparam dig_t  ALM_RST_HR1  = 4'd6;

endpackage

// File: rtl/alarm_time_reg.sv
// BCD hh:mm alarm-time register with wrap-around increment of hours and minutes.
module alarm_time_reg
  import clock_pkg::*;
(
  input  logic   clk_1sec,
  input  logic   reset_n,
  input  logic   en,
  input  logic   inc_hr,
  input  logic   inc_min,
  output hr10_t  hrs_10,
  output dig_t   hrs_1,
  output min10_t mins_10,
  output dig_t   mins_1
);

  hr10_t  hrs_10_q, hrs_10_d;
  dig_t   hrs_1_q, hrs_1_d;
  min10_t mins_10_q, mins_10_d;
  dig_t   mins_1_q, mins_1_d;

  always_comb begin
    hrs_10_d  = hrs_10_q;
    hrs_1_d   = hrs_1_q;
    mins_10_d = mins_10_q;
    mins_1_d  = mins_1_q;
    if (en && inc_hr) begin
      if (hrs_10_q == 2'd2 && hrs_1_q == 4'd3) begin
        hrs_10_d = 2'd0;
        hrs_1_d  = 4'd0;
      end else if (hrs_1_q == 4'd9) begin
        hrs_10_d = hrs_10_q + 2'd1;
        hrs_1_d  = 4'd0;
      end else begin
        hrs_1_d = hrs_1_q + 4'd1;
      end
    end
    // Minute wrap never carries into the hour.
    if (en && inc_min) begin
      if (mins_1_q == 4'd9) begin
        mins_1_d  = 4'd0;
        mins_10_d = (mins_10_q == 3'd5) ? 3'd0 : mins_10_q + 3'd1;
      end else begin
        mins_1_d = mins_1_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_1sec or negedge reset_n) begin
    if (!reset_n) begin
      hrs_10_q  <= ALM_RST_HR10;
      hrs_1_q   <= ALM_RST_HR1;
      mins_10_q <= 3'd0;
      mins_1_q  <= 4'd0;
    end else begin
      hrs_10_q  <= hrs_10_d;
      hrs_1_q   <= hrs_1_d;
      mins_10_q <= mins_10_d;
      mins_1_q  <= mins_1_d;
    end
  end

  assign hrs_10  = hrs_10_q;
  assign hrs_1   = hrs_1_q;
  assign mins_10 = mins_10_q;
  assign mins_1  = mins_1_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm FSM: compares time-of-day against the stored alarm, rings, snoozes and times out.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk_1sec,
  input  logic       reset_n,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       snooze,
  input  logic       stop,
  input  logic [1:0] cur_hrs_10,
  input  logic [3:0] cur_hrs_1,
  input  logic [2:0] cur_mins_10,
  input  logic [3:0] cur_mins_1,
  input  logic [5:0] cur_sec,
  output logic [1:0] alm_hrs_10,
  output logic [3:0] alm_hrs_1,
  output logic [2:0] alm_mins_10,
  output logic [3:0] alm_mins_1,
  output logic       buzzer,
  output logic       armed
);

  localparam int unsigned RingW    = $clog2(RING_SEC);
  localparam int unsigned SnzLeftW = $clog2(SNOOZE_SEC);
  localparam int unsigned SnzCntW  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [RingW-1:0]    RingLast = RingW'(RING_SEC - 1);
  localparam logic [SnzLeftW-1:0] SnzLoad  = SnzLeftW'(SNOOZE_SEC - 1);
  localparam logic [SnzCntW-1:0]  SnzMax   = SnzCntW'(MAX_SNOOZE);

  alarm_state_t        state_q, state_d;
  logic [RingW-1:0]    ring_cnt_q, ring_cnt_d;
  logic [SnzLeftW-1:0] snz_left_q, snz_left_d;
  logic [SnzCntW-1:0]  snz_cnt_q, snz_cnt_d;
  logic                buzzer_q, armed_q;
  logic                edit_en, match;

  assign edit_en = set_mode && (state_q == IDLE || state_q == ARMED);

  alarm_time_reg u_time_reg (
    .clk_1sec (clk_1sec),
    .reset_n  (reset_n),
    .en       (edit_en),
    .inc_hr   (inc_hr),
    .inc_min  (inc_min),
    .hrs_10   (alm_hrs_10),
    .hrs_1    (alm_hrs_1),
    .mins_10  (alm_mins_10),
    .mins_1   (alm_mins_1)
  );

  // Only the second-zero edge can match, so re-entering ARMED mid-minute never retriggers.
  assign match = (cur_hrs_10 == alm_hrs_10) && (cur_hrs_1 == alm_hrs_1) &&
                 (cur_mins_10 == alm_mins_10) && (cur_mins_1 == alm_mins_1) &&
                 (cur_sec == 6'd0);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_left_d = snz_left_q;
    snz_cnt_d  = snz_cnt_q;
    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = ARMED;
          end else if (snooze) begin
            if (snz_cnt_q < SnzMax) begin
              state_d    = SNOOZE;
              snz_left_d = SnzLoad;
              snz_cnt_d  = snz_cnt_q + 1'b1;
            end else begin
              state_d = ARMED;
            end
          end else if (ring_cnt_q == RingLast) begin
            state_d = ARMED;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = ARMED;
          end else if (snz_left_q == '0) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end else begin
            snz_left_d = snz_left_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1sec or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_left_q <= '0;
      snz_cnt_q  <= '0;
      buzzer_q   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_left_q <= snz_left_d;
      snz_cnt_q  <= snz_cnt_d;
      buzzer_q   <= (state_d == RINGING);
      armed_q    <= (state_d != IDLE);
    end
  end

  assign buzzer = buzzer_q;
  assign armed  = armed_q;

endmodule
